instruction_fetch_unit: RTL and testbench

//   Opcode-fetch sequencer directly upstream of the instruction decoder.

---
 rtl/instruction_fetch_unit_pkg.sv | 43 ++++
 rtl/instruction_fetch_unit_if.sv | 34 +++
 rtl/instruction_fetch_unit_pc_counter.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 83 ++++++++
 tb/tb_instruction_fetch_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the opcode-fetch sequencer: state encodings, bus status codes,
// the reset opcode and the state transition function.
package instruction_fetch_unit_pkg;

   typedef enum logic [2:0] {
      S_RST,
      S_T1,
      S_T2,
      S_TW,
      S_T3,
      S_SOD,
      S_WAIT_EOD,
      S_HALT
   } fetch_state_t;

   localparam logic [1:0] ST_FETCH   = 2'b11;
   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [7:0] NOP_OPCODE = 8'h00;

   function automatic fetch_state_t next_state(
      input fetch_state_t s,
      input logic         ready,
      input logic         eod,
      input logic         halt_req,
      input logic         resume
   );
      fetch_state_t n;
      n = s;
      case (s)
         S_RST:      n = S_T1;
         S_T1:       n = S_T2;
         S_T2:       n = ready ? S_T3 : S_TW;
         S_TW:       n = ready ? S_T3 : S_TW;
         S_T3:       n = S_SOD;
         S_SOD:      n = S_WAIT_EOD;
         S_WAIT_EOD: n = eod ? (halt_req ? S_HALT : S_T1) : S_WAIT_EOD;
         S_HALT:     n = resume ? S_T1 : S_HALT;
         default:    n = S_RST;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// External bus plus decoder handshake of the fetch unit; master is the fetch unit,
// slave is the memory/decoder side.
interface instruction_fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              ready;
   logic [DATA_W-1:0] data_in;
   logic [ADDR_W-1:0] addr_out;
   logic              ale;
   logic              rd_n;
   logic              iom;
   logic              s1;
   logic              s0;
   logic [DATA_W-1:0] ir;
   logic              sod;
   logic              eod;
   logic              pc_inc;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_load_val;
   logic              halt_req;
   logic              resume;
   logic [ADDR_W-1:0] pc_out;

   modport master (
      input  ready, data_in, eod, pc_inc, pc_load, pc_load_val, halt_req, resume,
      output addr_out, ale, rd_n, iom, s1, s0, ir, sod, pc_out
   );

   modport slave (
      output ready, data_in, eod, pc_inc, pc_load, pc_load_val, halt_req, resume,
      input  addr_out, ale, rd_n, iom, s1, s0, ir, sod, pc_out
   );
endinterface

// File: rtl/instruction_fetch_unit_pc_counter.sv
// Program counter: load has priority over increment, increment wraps at 2^ADDR_W.
// pc_nxt is exposed so the caller can register the address it is about to drive.
module instruction_fetch_unit_pc_counter #(
   parameter int                ADDR_W       = 16,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_nxt
);

   assign pc_nxt = load ? load_val : (inc ? pc + ADDR_W'(1) : pc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_VECTOR;
      end else begin
         pc <= pc_nxt;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Opcode-fetch sequencer: T1/T2/Tw/T3 bus cycle loads IR, then hands off to the decoder
// with a one-cycle sod and waits for eod. All bus outputs are registered from the next state.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W       = 16,
   parameter int                DATA_W       = 8,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   instruction_fetch_unit_if.master bus
);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] ir;
   logic [1:0]        status;
   logic              ale;
   logic              rd_n;
   logic              sod;
   logic              in_wait;
   logic              pc_ld;
   logic              pc_in;

   // Decoder PC requests only count while it owns the cycle (WAIT_EOD).
   assign in_wait   = (state == S_WAIT_EOD);
   assign pc_ld     = in_wait && bus.pc_load;
   assign pc_in     = (state == S_T3) || (in_wait && bus.pc_inc);
   assign state_nxt = next_state(state, bus.ready, bus.eod, bus.halt_req, bus.resume);

   instruction_fetch_unit_pc_counter #(
      .ADDR_W       (ADDR_W),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (pc_ld),
      .inc      (pc_in),
      .load_val (bus.pc_load_val),
      .pc       (pc),
      .pc_nxt   (pc_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_RST;
         addr   <= RESET_VECTOR;
         ir     <= DATA_W'(NOP_OPCODE);
         status <= ST_IDLE;
         ale    <= 1'b0;
         rd_n   <= 1'b1;
         sod    <= 1'b0;
      end else begin
         state  <= state_nxt;
         ale    <= (state_nxt == S_T1);
         rd_n   <= !(state_nxt inside {S_T2, S_TW, S_T3});
         status <= (state_nxt inside {S_T1, S_T2, S_TW, S_T3}) ? ST_FETCH : ST_IDLE;
         sod    <= (state_nxt == S_SOD);
         // Address picks up any same-cycle jump so T1 drives the target directly.
         if (state_nxt == S_T1) begin
            addr <= pc_nxt;
         end
         if (state == S_T3) begin
            ir <= bus.data_in;
         end
      end
   end

   assign bus.addr_out = addr;
   assign bus.ale      = ale;
   assign bus.rd_n     = rd_n;
   assign bus.iom      = 1'b0;
   assign bus.s1       = status[1];
   assign bus.s0       = status[0];
   assign bus.ir       = ir;
   assign bus.sod      = sod;
   assign bus.pc_out   = pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: bus-cycle level reference model compared every cycle,
// directed scenarios pinned with literal values, then randomized bus and decoder traffic.
module tb_instruction_fetch_unit;

   logic clk = 1'b0;
   logic rst_n;

   instruction_fetch_unit_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   instruction_fetch_unit #(
      .ADDR_W       (16),
      .DATA_W       (8),
      .RESET_VECTOR (16'h0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:65535];
   assign bus.data_in = mem[bus.addr_out];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: which bus phase we are in, counted in whole cycles.
   localparam int M_PRE = 0, M_FETCH = 1, M_SOD = 2, M_DEC = 3, M_HALT = 4;
   int         m_mode = M_PRE;
   int         m_k    = 0;
   bit         m_last = 1'b0;
   logic [15:0] m_pc   = 16'h0000;
   logic [15:0] m_addr = 16'h0000;
   logic [7:0]  m_ir   = 8'h00;

   task automatic start_fetch();
      m_mode = M_FETCH;
      m_k    = 0;
      m_last = 1'b0;
      m_addr = m_pc;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = M_PRE; m_k = 0; m_last = 1'b0;
         m_pc = 16'h0000; m_addr = 16'h0000; m_ir = 8'h00;
      end else begin
         case (m_mode)
            M_PRE:   start_fetch();
            M_FETCH: begin
               if (m_k == 0) m_k = 1;
               else if (m_last) begin
                  m_ir   = mem[m_addr];
                  m_pc   = m_pc + 16'd1;
                  m_mode = M_SOD;
               end else begin
                  if (bus.ready) m_last = 1'b1;
                  m_k++;
               end
            end
            M_SOD:   m_mode = M_DEC;
            M_DEC: begin
               if (bus.pc_load) m_pc = bus.pc_load_val;
               else if (bus.pc_inc) m_pc = m_pc + 16'd1;
               if (bus.eod) begin
                  if (bus.halt_req) m_mode = M_HALT;
                  else start_fetch();
               end
            end
            M_HALT:  if (bus.resume) start_fetch();
            default: m_mode = M_PRE;
         endcase
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [45:0] act, exp;
      logic        e_ale, e_rd_n, e_sod;
      logic [1:0]  e_st;
      e_ale  = (m_mode == M_FETCH) && (m_k == 0);
      e_rd_n = !((m_mode == M_FETCH) && (m_k > 0));
      e_st   = (m_mode == M_FETCH) ? 2'b11 : 2'b00;
      e_sod  = (m_mode == M_SOD);
      exp = {m_addr, e_ale, e_rd_n, 1'b0, e_st, m_ir, e_sod, m_pc};
      act = {bus.addr_out, bus.ale, bus.rd_n, bus.iom, bus.s1, bus.s0, bus.ir, bus.sod, bus.pc_out};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL model_cycle t=%0t {addr,ale,rd_n,iom,s1s0,ir,sod,pc} actual=%h expected=%h",
                  $time, act, exp);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_sod(input string name);
      int n = 0;
      while (bus.sod !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk(name, {31'd0, bus.sod}, 32'd1);
   endtask

   initial begin
      int rd_low, halt_bad, sod_in_rst;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h0000] = 8'h3E;
      mem[16'h2000] = 8'hC3;
      mem[16'hFFFF] = 8'hA5;

      rst_n = 1'b0;
      bus.ready = 1'b1; bus.eod = 1'b0; bus.pc_inc = 1'b0; bus.pc_load = 1'b0;
      bus.pc_load_val = 16'h0000; bus.halt_req = 1'b0; bus.resume = 1'b0;
      repeat (3) tick();
      chk("rst_ale", {31'd0, bus.ale}, 32'd0);
      chk("rst_rd_n", {31'd0, bus.rd_n}, 32'd1);
      chk("rst_ir", {24'd0, bus.ir}, 32'h00);
      chk("rst_addr", {16'd0, bus.addr_out}, 32'h0000);
      rst_n = 1'b1;

      // First fetch from the reset vector with ready held high.
      tick();
      chk("c1_ale", {31'd0, bus.ale}, 32'd1);
      chk("c1_addr", {16'd0, bus.addr_out}, 32'h0000);
      chk("c1_status", {30'd0, bus.s1, bus.s0}, 32'd3);
      tick();
      chk("c2_rd_n", {31'd0, bus.rd_n}, 32'd0);
      tick();
      chk("c3_rd_n", {31'd0, bus.rd_n}, 32'd0);
      tick();
      chk("c4_sod", {31'd0, bus.sod}, 32'd1);
      chk("c4_ir", {24'd0, bus.ir}, 32'h3E);
      chk("c4_pc", {16'd0, bus.pc_out}, 32'h0001);
      tick();
      chk("c5_sod_pulse", {31'd0, bus.sod}, 32'd0);

      // Load and increment together with eod: load wins and feeds the next T1.
      bus.pc_load = 1'b1; bus.pc_inc = 1'b1; bus.pc_load_val = 16'h2000; bus.eod = 1'b1;
      tick();
      bus.pc_load = 1'b0; bus.pc_inc = 1'b0; bus.eod = 1'b0;
      chk("jump_ale", {31'd0, bus.ale}, 32'd1);
      chk("jump_addr", {16'd0, bus.addr_out}, 32'h2000);

      // Three wait states; stray pc_inc, eod and resume during the bus cycle are ignored.
      bus.ready = 1'b0;
      rd_low = 0;
      tick();                                        // T2
      rd_low += (bus.rd_n == 1'b0 && bus.addr_out == 16'h2000) ? 1 : 0;
      bus.pc_inc = 1'b1;
      tick();                                        // TW1
      rd_low += (bus.rd_n == 1'b0 && bus.addr_out == 16'h2000) ? 1 : 0;
      bus.pc_inc = 1'b0; bus.eod = 1'b1;
      tick();                                        // TW2
      rd_low += (bus.rd_n == 1'b0 && bus.addr_out == 16'h2000) ? 1 : 0;
      bus.eod = 1'b0; bus.resume = 1'b1;
      tick();                                        // TW3
      rd_low += (bus.rd_n == 1'b0 && bus.addr_out == 16'h2000) ? 1 : 0;
      bus.resume = 1'b0; bus.ready = 1'b1;
      chk("tw_no_sod", {31'd0, bus.sod}, 32'd0);
      tick();                                        // T3
      rd_low += (bus.rd_n == 1'b0 && bus.addr_out == 16'h2000) ? 1 : 0;
      chk("tw_ir_not_yet", {24'd0, bus.ir}, 32'h3E);
      tick();                                        // SOD
      chk("tw_read_cycles", rd_low, 32'd5);
      chk("tw_sod_late", {31'd0, bus.sod}, 32'd1);
      chk("tw_ir", {24'd0, bus.ir}, 32'hC3);
      chk("tw_pc", {16'd0, bus.pc_out}, 32'h2001);
      bus.eod = 1'b1;                                // eod during SOD must not end decode
      tick();
      chk("sod_eod_ignored", {31'd0, bus.ale}, 32'd0);

      // Halt, hold for ten cycles, then resume at the next PC.
      bus.halt_req = 1'b1;
      tick();
      bus.eod = 1'b0; bus.halt_req = 1'b0; bus.pc_inc = 1'b1;
      halt_bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.ale || bus.s1 || bus.s0 || !bus.rd_n) halt_bad++;
      end
      chk("halt_idle_cycles", halt_bad, 32'd0);
      chk("halt_pc_held", {16'd0, bus.pc_out}, 32'h2001);
      bus.pc_inc = 1'b0; bus.resume = 1'b1;
      tick();
      bus.resume = 1'b0;
      chk("resume_ale", {31'd0, bus.ale}, 32'd1);
      chk("resume_addr", {16'd0, bus.addr_out}, 32'h2001);
      wait_sod("resume_sod");
      tick();

      // Fetch at the top of the address space wraps the PC.
      bus.pc_load = 1'b1; bus.pc_load_val = 16'hFFFF; bus.eod = 1'b1;
      tick();
      bus.pc_load = 1'b0; bus.eod = 1'b0;
      chk("wrap_addr", {16'd0, bus.addr_out}, 32'hFFFF);
      wait_sod("wrap_sod");
      chk("wrap_pc", {16'd0, bus.pc_out}, 32'h0000);
      chk("wrap_ir", {24'd0, bus.ir}, 32'hA5);
      tick();

      // Asynchronous reset in the middle of a wait state.
      bus.eod = 1'b1; bus.ready = 1'b0;
      tick();
      bus.eod = 1'b0;
      tick();
      tick();
      chk("mid_tw_rd_n", {31'd0, bus.rd_n}, 32'd0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_ale", {31'd0, bus.ale}, 32'd0);
      chk("arst_rd_n", {31'd0, bus.rd_n}, 32'd1);
      chk("arst_status", {30'd0, bus.s1, bus.s0}, 32'd0);
      chk("arst_ir", {24'd0, bus.ir}, 32'h00);
      chk("arst_addr", {16'd0, bus.addr_out}, 32'h0000);
      chk("arst_pc", {16'd0, bus.pc_out}, 32'h0000);
      bus.ready = 1'b1;
      sod_in_rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.sod) sod_in_rst++;
      end
      chk("arst_no_sod", sod_in_rst, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rerun_ale", {31'd0, bus.ale}, 32'd1);
      chk("rerun_addr", {16'd0, bus.addr_out}, 32'h0000);

      // Randomized memory readiness and decoder behaviour.
      for (int i = 0; i < 3000; i++) begin
         bus.ready       = ($urandom_range(0, 99) < 65);
         bus.eod         = ($urandom_range(0, 99) < 25);
         bus.pc_inc      = ($urandom_range(0, 99) < 30);
         bus.pc_load     = ($urandom_range(0, 99) < 15);
         bus.pc_load_val = 16'($urandom);
         bus.halt_req    = ($urandom_range(0, 99) < 10);
         bus.resume      = ($urandom_range(0, 99) < 20);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
